e1_tick_capture_wb: RTL and testbench

Wishbone responder on one of the SoC's external peripheral slots (`wb_m_*`) that counts the E1 RX/TX frame ticks per channel and the USB SOF ticks. On each USB SOF it atomically snapshots all counters. Firmware reads the snapshot to estimate E1 clock rate against the USB host frame clock, for rate matching. All inputs are already in `clk_sys`.

---
 rtl/e1_tick_capture_wb.sv | 87 ++++++++
 tb/tb_e1_tick_capture_wb.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/e1_tick_capture_wb.sv
// e1_tick_capture_wb: per-channel E1 frame tick counters snapshotted on USB SOF, Wishbone readable.
// Define TICKCAP_TIMESTAMP_EN to add a free-running cycle counter captured into TS.
module e1_tick_capture_wb #(
  parameter int N = 1
) (
  input  logic          clk_sys,
  input  logic          rst_sys,
  input  logic [3:0]    wb_addr,
  output logic [31:0]   wb_rdata,
  input  logic [31:0]   wb_wdata,
  input  logic [3:0]    wb_wmsk,
  input  logic          wb_we,
  input  logic          wb_cyc,
  output logic          wb_ack,
  input  logic [N-1:0]  tick_e1_rx,
  input  logic [N-1:0]  tick_e1_tx,
  input  logic          tick_usb_sof
);
  logic        en, pend, ovr, cap, acc, wr;
  logic [15:0] sof_cnt;
  logic [31:0] cap_w [2];
  logic [31:0] ts_rd, rd;
  logic        unused_bits;
  assign unused_bits = ^{wb_wdata[31:3], wb_wmsk[3:1]};
  assign acc = wb_cyc & ~wb_ack;
  assign wr  = acc & wb_we & (wb_addr == 4'd0) & wb_wmsk[0];
  assign cap = tick_usb_sof & en;
  always_ff @(posedge clk_sys or posedge rst_sys) begin
    if (rst_sys) begin
      wb_ack   <= 1'b0;
      wb_rdata <= '0;
      en       <= 1'b0;
      pend     <= 1'b0;
      ovr      <= 1'b0;
      sof_cnt  <= '0;
    end else begin
      wb_ack   <= acc;
      wb_rdata <= (acc & ~wb_we) ? rd : '0;
      en       <= wr ? wb_wdata[0] : en;
      // a capture wins over a same-cycle W1C; OVR looks at PEND before this edge
      pend     <= cap | (pend & ~(wr & wb_wdata[1]));
      ovr      <= (cap & pend) | (ovr & ~(wr & wb_wdata[2]));
      sof_cnt  <= sof_cnt + 16'(cap);
    end
  end
  for (genvar i = 0; i < 2; i++) begin : g_ch
    if (i < N) begin : g_on
      logic [15:0] rx, tx;
      logic [31:0] cap_r;
      always_ff @(posedge clk_sys or posedge rst_sys) begin
        if (rst_sys) begin
          rx    <= '0;
          tx    <= '0;
          cap_r <= '0;
        end else begin
          rx <= en ? rx + 16'(tick_e1_rx[i]) : '0;
          tx <= en ? tx + 16'(tick_e1_tx[i]) : '0;
          if (cap) cap_r <= {tx, rx};
        end
      end
      assign cap_w[i] = cap_r;
    end else begin : g_off
      assign cap_w[i] = '0;
    end
  end
`ifdef TICKCAP_TIMESTAMP_EN
  logic [31:0] ts_cnt, ts_cap;
  always_ff @(posedge clk_sys or posedge rst_sys) begin
    if (rst_sys) begin
      ts_cnt <= '0;
      ts_cap <= '0;
    end else begin
      ts_cnt <= ts_cnt + 32'd1;
      if (cap) ts_cap <= ts_cnt;
    end
  end
  assign ts_rd = ts_cap;
`else
  assign ts_rd = '0;
`endif
  always_comb begin
    rd = (wb_addr == 4'd0) ? {sof_cnt, 13'd0, ovr, pend, en} :
         (wb_addr == 4'd1) ? cap_w[0] :
         (wb_addr == 4'd2) ? cap_w[1] :
         (wb_addr == 4'd3) ? ts_rd : '0;
  end
endmodule

// File: tb/tb_e1_tick_capture_wb.sv
// tb_e1_tick_capture_wb: directed and randomized checks of e1_tick_capture_wb against a behavioural model.
module tb_e1_tick_capture_wb;
  localparam int NCH = 2;
`ifdef TICKCAP_TIMESTAMP_EN
  localparam bit TS_ON = 1'b1;
`else
  localparam bit TS_ON = 1'b0;
`endif
  logic        clk_sys = 1'b0;
  logic        rst_sys = 1'b1;
  logic [3:0]  wb_addr = '0;
  logic [31:0] wb_rdata;
  logic [31:0] wb_wdata = '0;
  logic [3:0]  wb_wmsk = '0;
  logic        wb_we = 1'b0;
  logic        wb_cyc = 1'b0;
  logic        wb_ack;
  logic [NCH-1:0] tick_e1_rx = '0;
  logic [NCH-1:0] tick_e1_tx = '0;
  logic        tick_usb_sof = 1'b0;

  e1_tick_capture_wb #(.N(NCH)) dut (
    .clk_sys(clk_sys), .rst_sys(rst_sys), .wb_addr(wb_addr), .wb_rdata(wb_rdata),
    .wb_wdata(wb_wdata), .wb_wmsk(wb_wmsk), .wb_we(wb_we), .wb_cyc(wb_cyc), .wb_ack(wb_ack),
    .tick_e1_rx(tick_e1_rx), .tick_e1_tx(tick_e1_tx), .tick_usb_sof(tick_usb_sof)
  );

  always #5 clk_sys = ~clk_sys;

  int checks = 0;
  int failures = 0;

  // Reference state: live counts, snapshots, CSR fields, cycle count since reset
  logic [15:0] m_rx [2];
  logic [15:0] m_tx [2];
  logic [31:0] m_cap [2];
  logic [31:0] m_cap_ts, m_ts;
  logic [15:0] m_sof;
  logic        m_en, m_pend, m_ovr, m_ack;
  logic [31:0] rd_data, t1, t2;
  logic [15:0] sc;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] m_reg(input logic [3:0] a);
    case (a)
      4'd0: return {m_sof, 13'd0, m_ovr, m_pend, m_en};
      4'd1: return m_cap[0];
      4'd2: return (NCH > 1) ? m_cap[1] : 32'd0;
      4'd3: return TS_ON ? m_cap_ts : 32'd0;
      default: return 32'd0;
    endcase
  endfunction

  task automatic model_reset();
    for (int c = 0; c < 2; c++) begin
      m_rx[c] = '0; m_tx[c] = '0; m_cap[c] = '0;
    end
    m_cap_ts = '0; m_ts = '0; m_sof = '0;
    m_en = 0; m_pend = 0; m_ovr = 0; m_ack = 0;
  endtask

  // Advance one clock: predict from current inputs, then compare ack/rdata after the edge
  task automatic step();
    logic cap, wr, ea, ew, pp;
    logic [31:0] rv;
    cap = tick_usb_sof && m_en;
    ea  = wb_cyc && !m_ack;
    ew  = wb_we;
    wr  = ea && wb_we && wb_addr == 4'd0 && wb_wmsk[0];
    rv  = (ea && !wb_we) ? m_reg(wb_addr) : 32'd0;
    pp  = m_pend;
    if (cap) begin
      for (int c = 0; c < 2; c++) m_cap[c] = {m_tx[c], m_rx[c]};
      m_cap_ts = m_ts;
    end
    for (int c = 0; c < NCH; c++) begin
      m_rx[c] = m_en ? m_rx[c] + 16'(tick_e1_rx[c]) : 16'd0;
      m_tx[c] = m_en ? m_tx[c] + 16'(tick_e1_tx[c]) : 16'd0;
    end
    if (wr && wb_wdata[1]) m_pend = 0;
    if (wr && wb_wdata[2]) m_ovr = 0;
    if (wr) m_en = wb_wdata[0];
    if (cap) begin
      if (pp) m_ovr = 1;
      m_pend = 1;
      m_sof++;
    end
    m_ts++;
    m_ack = ea;
    @(posedge clk_sys);
    #1;
    chk("ack", 32'(wb_ack), 32'(ea));
    if (!(ea && ew)) chk("rdata", wb_rdata, rv);
  endtask

  task automatic rd(input logic [3:0] a);
    wb_addr = a; wb_we = 0; wb_cyc = 1;
    step();
    rd_data = wb_rdata;
    wb_cyc = 0;
    step();
  endtask

  task automatic wrt(input logic [31:0] d, input logic [3:0] m, input logic [3:0] a, input logic s);
    wb_addr = a; wb_wdata = d; wb_wmsk = m; wb_we = 1; wb_cyc = 1;
    if (s) tick_usb_sof = 1;
    step();
    if (s) tick_usb_sof = 0;
    wb_cyc = 0; wb_we = 0;
    step();
  endtask

  task automatic tk(input logic [1:0] rx, input logic [1:0] tx, input logic s);
    tick_e1_rx = rx; tick_e1_tx = tx; tick_usb_sof = s;
    step();
    tick_e1_rx = '0; tick_e1_tx = '0; tick_usb_sof = 0;
  endtask

  initial begin
    model_reset();
    repeat (3) @(posedge clk_sys);
    #1;
    chk("rst_ack", 32'(wb_ack), 32'd0);
    chk("rst_rdata", wb_rdata, 32'd0);
    rst_sys = 0;
    for (int a = 0; a < 16; a++) begin
      rd(4'(a));
      chk($sformatf("rst_read_%0d", a), rd_data, 32'd0);
    end
    wrt(32'h1, 4'h1, 4'd0, 0);
    for (int i = 0; i < 100; i++) tk(2'b01, {1'b0, 1'(i < 37)}, 0);
    tk(2'b00, 2'b00, 1);
    rd(4'd1); chk("cap0_100_37", rd_data, 32'h00250064);
    rd(4'd0); chk("csr_first_cap", rd_data, 32'h00010003);
    wrt(32'h0, 4'h1, 4'd0, 0);
    wrt(32'h1, 4'h1, 4'd0, 0);
    repeat (5) tk(2'b01, 2'b00, 0);
    tk(2'b01, 2'b00, 1);
    rd(4'd1); chk("same_cycle_tick", 32'(rd_data[15:0]), 32'd5);
    tk(2'b00, 2'b00, 1);
    rd(4'd1); chk("tick_next_interval", 32'(rd_data[15:0]), 32'd6);
    wrt(32'h7, 4'h1, 4'd0, 0);
    tk(2'b00, 2'b00, 1);
    tk(2'b00, 2'b00, 1);
    rd(4'd0); chk("ovr_two_sof", 32'(rd_data[2:0]), 32'h7);
    wrt(32'h7, 4'h1, 4'd0, 1);
    rd(4'd0); chk("w1c_vs_capture", 32'(rd_data[2:0]), 32'h7);
    wrt(32'h7, 4'h1, 4'd0, 0);
    rd(4'd0); chk("w1c_clear", 32'(rd_data[2:0]), 32'h1);
    wrt(32'h0, 4'he, 4'd0, 0);
    rd(4'd0); chk("wmsk_byte0_off", 32'(rd_data[0]), 32'd1);
    wrt(32'h0, 4'hf, 4'd5, 0);
    rd(4'd0); chk("write_other_addr", 32'(rd_data[0]), 32'd1);
    wrt(32'h0, 4'h1, 4'd0, 0);
    wrt(32'h1, 4'h1, 4'd0, 0);
    repeat (65537) tk(2'b01, 2'b00, 0);
    tk(2'b00, 2'b00, 1);
    rd(4'd1); chk("rx_wrap", 32'(rd_data[15:0]), 32'd1);
    rd(4'd0); sc = rd_data[31:16];
    wrt(32'h0, 4'h1, 4'd0, 0);
    repeat (10) tk(2'b11, 2'b11, 0);
    tk(2'b00, 2'b00, 1);
    rd(4'd0); chk("en0_sofcnt_held", 32'(rd_data[31:16]), 32'(sc));
    rd(4'd1); chk("en0_cap_held", 32'(rd_data[15:0]), 32'd1);
    wrt(32'h1, 4'h1, 4'd0, 0);
    tk(2'b00, 2'b00, 1);
    rd(4'd1); chk("live_zero_ch0", rd_data, 32'd0);
    rd(4'd2); chk("live_zero_ch1", rd_data, 32'd0);
    tk(2'b00, 2'b00, 1);
    rd(4'd3); t1 = rd_data;
    repeat (997) step();
    tk(2'b00, 2'b00, 1);
    rd(4'd3); t2 = rd_data;
    chk("ts_delta", t2 - t1, TS_ON ? 32'd1000 : 32'd0);
    chk("ts_value", t2, m_reg(4'd3));
    wb_addr = 4'd0; wb_we = 0; wb_cyc = 1;
    repeat (4) step();
    wb_cyc = 0;
    step();
    for (int i = 0; i < 2000; i++) begin
      tick_e1_rx = 2'($urandom);
      tick_e1_tx = 2'($urandom);
      tick_usb_sof = ($urandom_range(0, 29) == 0);
      case ($urandom_range(0, 9))
        0, 1: rd(4'($urandom));
        2: wrt($urandom | 32'($urandom_range(0, 3) != 0), 4'($urandom),
               ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'd0, 0);
        default: step();
      endcase
      tick_e1_rx = '0; tick_e1_tx = '0; tick_usb_sof = 0;
    end
    for (int a = 0; a < 4; a++) begin
      rd(4'(a));
      chk($sformatf("rand_final_%0d", a), rd_data, m_reg(4'(a)));
    end
    wb_addr = 4'd1; wb_we = 0; wb_cyc = 1;
    step();
    #2 rst_sys = 1;
    #1;
    chk("rst_mid_ack", 32'(wb_ack), 32'd0);
    chk("rst_mid_rdata", wb_rdata, 32'd0);
    wb_cyc = 0;
    @(posedge clk_sys);
    #1;
    rst_sys = 0;
    model_reset();
    rd(4'd0); chk("post_rst_csr", rd_data, 32'd0);
    rd(4'd1); chk("post_rst_cap0", rd_data, 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
